encoder_scan: RTL and testbench

Parametrised, registered successor to the combinational 8-to-3 encoder. Latches an N-bit high-active request vector and, over successive cycles, drains it by emitting the binary index of each set bit in a fixed priority order, one index per valid/ack handshake. The block sits between request-gathering logic (interrupt lines, key scans, channel flags) and a consumer that serves one index at a time. Multi-hot inputs are fully handled: no request is lost or merged.

---
 rtl/enc_pkg.sv | 9 +
 rtl/prio_enc_comb.sv | 29 ++
 rtl/encoder_scan.sv | 100 ++++++++++
 tb/tb_encoder_scan.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// Shared types for the encoder_scan request drainer.
package enc_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      DRAIN = 1'b1
   } state_e;

endpackage

// File: rtl/prio_enc_comb.sv
// Combinational N-to-W priority encoder with selectable search direction and an any flag.
module prio_enc_comb #(
   parameter int unsigned N         = 8,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic [N-1:0]         req_i,
   output logic [$clog2(N)-1:0] idx_o,
   output logic                 any_o
);

   localparam int unsigned W = $clog2(N);

   // The last matching iteration wins, so the loop order sets the priority.
   always_comb begin
      idx_o = '0;
      if (MSB_FIRST) begin
         for (int i = 0; i < int'(N); i++) begin
            if (req_i[i]) idx_o = W'(i);
         end
      end else begin
         for (int i = int'(N) - 1; i >= 0; i--) begin
            if (req_i[i]) idx_o = W'(i);
         end
      end
   end

   assign any_o = |req_i;

endmodule

// File: rtl/encoder_scan.sv
// Latches a request vector and drains it one index per valid/ack handshake in fixed priority.
module encoder_scan
   import enc_pkg::*;
#(
   parameter int unsigned N         = 8,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic                 iClk,
   input  logic                 iRst_n,
   input  logic [N-1:0]         iData,
   input  logic                 iLoad,
   output logic                 oReady,
   output logic [$clog2(N)-1:0] oData,
   output logic                 oValid,
   input  logic                 iAck,
   output logic                 oNone,
   output logic [$clog2(N):0]   oRemain
);

   localparam int unsigned W = $clog2(N);
   localparam logic [W:0]  CntOne = {{W{1'b0}}, 1'b1};

   state_e         state_q, state_d;
   logic [N-1:0]   pending_q, pending_d;
   logic [W:0]     cnt_q, cnt_d;
   logic           none_q, none_d;

   logic [W-1:0]   pend_idx;
   logic           pend_any;
   logic [N-1:0]   clr_mask;
   logic [W:0]     load_cnt;

   prio_enc_comb #(
      .N         (N),
      .MSB_FIRST (MSB_FIRST)
   ) u_prio (
      .req_i (pending_q),
      .idx_o (pend_idx),
      .any_o (pend_any)
   );

   assign clr_mask = {{(N - 1){1'b0}}, 1'b1} << pend_idx;

   // Popcount is taken only at load time; afterwards the counter just steps down per ack.
   always_comb begin
      load_cnt = '0;
      for (int i = 0; i < int'(N); i++) begin
         load_cnt = load_cnt + {{W{1'b0}}, iData[i]};
      end
   end

   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      cnt_d     = cnt_q;
      none_d    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (iLoad) begin
               pending_d = iData;
               cnt_d     = load_cnt;
               if (iData != '0) begin
                  state_d = DRAIN;
               end else begin
                  none_d = 1'b1;
               end
            end
         end
         DRAIN: begin
            if (iAck) begin
               pending_d = pending_q & ~clr_mask;
               cnt_d     = cnt_q - CntOne;
               if (cnt_q == CntOne) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge iClk) begin
      if (!iRst_n) begin
         state_q   <= IDLE;
         pending_q <= '0;
         cnt_q     <= '0;
         none_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         cnt_q     <= cnt_d;
         none_q    <= none_d;
      end
   end

   assign oReady  = (state_q == IDLE);
   assign oValid  = (state_q == DRAIN) && pend_any;
   assign oData   = oValid ? pend_idx : '0;
   assign oRemain = oValid ? cnt_q : '0;
   assign oNone   = none_q;

endmodule

// File: tb/tb_encoder_scan.sv
// Directed bench for encoder_scan: N=8 MSB-first and N=12 LSB-first instances.
module tb_encoder_scan;

   logic       clk;
   logic       rst_n;

   logic [7:0] data8;
   logic       load8, ack8;
   logic       ready8, valid8, none8;
   logic [2:0] odata8;
   logic [3:0] rem8;

   logic [11:0] data12;
   logic        load12, ack12;
   logic        ready12, valid12, none12;
   logic [3:0]  odata12;
   logic [4:0]  rem12;

   int n_cmp = 0;
   int n_err = 0;

   encoder_scan #(
      .N         (8),
      .MSB_FIRST (1'b1)
   ) u_dut8 (
      .iClk    (clk),
      .iRst_n  (rst_n),
      .iData   (data8),
      .iLoad   (load8),
      .oReady  (ready8),
      .oData   (odata8),
      .oValid  (valid8),
      .iAck    (ack8),
      .oNone   (none8),
      .oRemain (rem8)
   );

   encoder_scan #(
      .N         (12),
      .MSB_FIRST (1'b0)
   ) u_dut12 (
      .iClk    (clk),
      .iRst_n  (rst_n),
      .iData   (data12),
      .iLoad   (load12),
      .oReady  (ready12),
      .oData   (odata12),
      .oValid  (valid12),
      .iAck    (ack12),
      .oNone   (none12),
      .oRemain (rem12)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance one edge and settle; inputs are changed right after this returns.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle8(input string tag, input logic exp_none);
      check_eq({tag, " ready"}, 32'(ready8), 32'd1);
      check_eq({tag, " valid"}, 32'(valid8), 32'd0);
      check_eq({tag, " data"},  32'(odata8), 32'd0);
      check_eq({tag, " rem"},   32'(rem8),   32'd0);
      check_eq({tag, " none"},  32'(none8),  32'(exp_none));
   endtask

   task automatic check_drain8(input string tag, input int exp_idx, input int exp_rem);
      check_eq({tag, " valid"}, 32'(valid8), 32'd1);
      check_eq({tag, " ready"}, 32'(ready8), 32'd0);
      check_eq({tag, " data"},  32'(odata8), 32'(exp_idx));
      check_eq({tag, " rem"},   32'(rem8),   32'(exp_rem));
   endtask

   int exp_idx2 [4] = '{7, 5, 2, 1};
   int exp_rem2 [4] = '{4, 3, 2, 1};

   initial begin
      rst_n  = 1'b0;
      data8  = '0; load8  = 1'b0; ack8  = 1'b0;
      data12 = '0; load12 = 1'b0; ack12 = 1'b0;
      tick();
      tick();
      check_idle8("por", 1'b0);
      rst_n = 1'b1;
      tick();

      // Reset asserted mid-drain.
      data8 = 8'b1010_0110; load8 = 1'b1;
      tick();
      load8 = 1'b0;
      check_drain8("pre_rst", 7, 4);
      rst_n = 1'b0;
      tick();
      check_idle8("rst1", 1'b0);
      tick();
      check_idle8("rst2", 1'b0);
      rst_n = 1'b1;
      tick();
      check_idle8("rst_rel", 1'b0);

      // Full drain with ack held high.
      data8 = 8'b1010_0110; load8 = 1'b1;
      tick();
      load8 = 1'b0; ack8 = 1'b1; data8 = 8'hFF;
      for (int i = 0; i < 4; i++) begin
         check_drain8($sformatf("drain%0d", i), exp_idx2[i], exp_rem2[i]);
         tick();
      end
      ack8 = 1'b0;
      check_idle8("drain_end", 1'b0);

      // Back-pressure while index 5 is presented.
      data8 = 8'b1010_0110; load8 = 1'b1;
      tick();
      load8 = 1'b0; ack8 = 1'b1;
      check_drain8("bp_first", 7, 4);
      tick();
      ack8 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check_drain8($sformatf("bp_hold%0d", i), 5, 3);
         tick();
      end
      check_drain8("bp_hold3", 5, 3);
      ack8 = 1'b1;
      tick();
      check_drain8("bp_after", 2, 2);
      tick();
      check_drain8("bp_last", 1, 1);
      tick();
      ack8 = 1'b0;
      check_idle8("bp_end", 1'b0);

      // Empty load: single-cycle oNone.
      data8 = 8'h00; load8 = 1'b1;
      tick();
      load8 = 1'b0;
      check_idle8("none_pulse", 1'b1);
      tick();
      check_idle8("none_clear", 1'b0);

      // Load attempt during a drain is ignored.
      data8 = 8'hFF; load8 = 1'b1;
      tick();
      load8 = 1'b0; ack8 = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check_drain8($sformatf("ff%0d", i), 7 - i, 8 - i);
         if (i == 2) begin
            data8 = 8'h01; load8 = 1'b1;
         end else begin
            load8 = 1'b0;
         end
         tick();
      end
      ack8 = 1'b0; load8 = 1'b0;
      check_idle8("ff_end", 1'b0);
      tick();
      check_idle8("ff_after", 1'b0);

      // N=12 LSB-first instance.
      data12 = 12'h801; load12 = 1'b1;
      tick();
      load12 = 1'b0; ack12 = 1'b1;
      check_eq("n12 valid0", 32'(valid12), 32'd1);
      check_eq("n12 data0",  32'(odata12), 32'd0);
      check_eq("n12 rem0",   32'(rem12),   32'd2);
      tick();
      check_eq("n12 data1",  32'(odata12), 32'd11);
      check_eq("n12 rem1",   32'(rem12),   32'd1);
      tick();
      ack12 = 1'b0;
      check_eq("n12 valid_end", 32'(valid12), 32'd0);
      check_eq("n12 ready_end", 32'(ready12), 32'd1);
      check_eq("n12 none",      32'(none12),  32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
